prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 21 ++
 rtl/prog_loader.sv | 122 ++++++++++++
 tb/tb_prog_loader.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the byte-stream program loader.
package prog_loader_pkg;

   localparam logic [7:0]   SYNC_BYTE_DEF = 8'hA5;
   localparam int unsigned  MAX_WORDS_DEF = 2048;
   localparam int unsigned  BYTE_W        = 8;
   localparam int unsigned  WORD_W        = 16;

   typedef enum logic [3:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA_LO,
      DATA_HI,
      WRITE,
      CHECK,
      DONE,
      ERR
   } state_t;

endpackage

// File: rtl/prog_loader.sv
// Receives a framed byte stream (sync, length, 16-bit words, XOR checksum) and
// writes each word into the core's instruction memory, releasing the core on success.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
   parameter int unsigned MAX_WORDS = MAX_WORDS_DEF
) (
   input  logic              clk,
   input  logic              rstz,
   input  logic [BYTE_W-1:0] rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [WORD_W-1:0] pg_instr,
   output logic              pg,
   output logic [WORD_W-1:0] pg_addr,
   output logic              core_rstz,
   output logic              busy,
   output logic              err
);

   state_t              state, state_next;
   logic [WORD_W-1:0]   len, len_next;
   logic [WORD_W-1:0]   word_cnt, cnt_next;
   logic [BYTE_W-1:0]   csum, csum_next;
   logic [WORD_W-1:0]   instr_next, addr_next;
   logic [WORD_W-1:0]   len_full;
   logic                accept;

   assign accept   = rx_valid & rx_ready;
   assign len_full = {rx_data, len[BYTE_W-1:0]};

   // State and datapath registers; status outputs are decoded from the next state
   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz) begin
         state     <= IDLE;
         len       <= '0;
         word_cnt  <= '0;
         csum      <= '0;
         pg_instr  <= '0;
         pg_addr   <= '0;
         pg        <= 1'b0;
         rx_ready  <= 1'b1;
         core_rstz <= 1'b0;
         busy      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_next;
         len       <= len_next;
         word_cnt  <= cnt_next;
         csum      <= csum_next;
         pg_instr  <= instr_next;
         pg_addr   <= addr_next;
         pg        <= (state_next == WRITE);
         rx_ready  <= (state_next != WRITE);
         core_rstz <= (state_next == DONE);
         busy      <= (state_next inside {LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, CHECK});
         err       <= (state_next == ERR);
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_next = state;
      len_next   = len;
      cnt_next   = word_cnt;
      csum_next  = csum;
      instr_next = pg_instr;
      addr_next  = pg_addr;
      case (state)
         IDLE, DONE, ERR: begin
            if (accept && (rx_data == SYNC_BYTE)) begin
               state_next = LEN_LO;
               len_next   = '0;
               cnt_next   = '0;
               csum_next  = '0;
               addr_next  = '0;
            end
         end
         LEN_LO: begin
            if (accept) begin
               len_next   = {len[WORD_W-1:BYTE_W], rx_data};
               csum_next  = csum ^ rx_data;
               state_next = LEN_HI;
            end
         end
         LEN_HI: begin
            if (accept) begin
               len_next  = len_full;
               csum_next = csum ^ rx_data;
               if (32'(len_full) > MAX_WORDS)  state_next = ERR;
               else if (len_full == '0)        state_next = CHECK;
               else                            state_next = DATA_LO;
            end
         end
         DATA_LO: begin
            if (accept) begin
               instr_next = {pg_instr[WORD_W-1:BYTE_W], rx_data};
               csum_next  = csum ^ rx_data;
               state_next = DATA_HI;
            end
         end
         DATA_HI: begin
            if (accept) begin
               instr_next = {rx_data, pg_instr[BYTE_W-1:0]};
               csum_next  = csum ^ rx_data;
               state_next = WRITE;
            end
         end
         WRITE: begin
            addr_next  = pg_addr + WORD_W'(2);
            cnt_next   = word_cnt + WORD_W'(1);
            state_next = (cnt_next == len) ? CHECK : DATA_LO;
         end
         CHECK: begin
            if (accept) state_next = (rx_data == csum) ? DONE : ERR;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes queued per frame, checked on each pg pulse.
module tb_prog_loader;
   logic        clk = 1'b0;
   logic        rstz = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [15:0] pg_instr;
   logic        pg;
   logic [15:0] pg_addr;
   logic        core_rstz;
   logic        busy;
   logic        err;

   int tests_run = 0;
   int tests_failed = 0;
   int pulses = 0;

   logic [31:0] exp_q[$];
   logic [7:0]  tx_q[$];
   logic [15:0] word_q[$];

   prog_loader dut (
      .clk(clk), .rstz(rstz), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .pg_instr(pg_instr), .pg(pg), .pg_addr(pg_addr),
      .core_rstz(core_rstz), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // Pulse monitor: every pg pulse must match the head of the scoreboard, and rx_ready drops only with pg
   always @(negedge clk) begin
      if (rstz) begin
         if (pg) begin
            pulses++;
            tests_run++;
            if (exp_q.size() == 0) begin
               tests_failed++;
               $display("FAIL unexpected_pg: got instr=%h addr=%h, required no pulse", pg_instr, pg_addr);
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               if ({pg_instr, pg_addr} !== e) begin
                  tests_failed++;
                  $display("FAIL pg_write: got instr=%h addr=%h, required instr=%h addr=%h",
                           pg_instr, pg_addr, e[31:16], e[15:0]);
               end
            end
            tests_run++;
            if (rx_ready !== 1'b0) begin
               tests_failed++;
               $display("FAIL ready_in_write: got %b, required 0", rx_ready);
            end
         end else begin
            tests_run++;
            if (rx_ready !== 1'b1) begin
               tests_failed++;
               $display("FAIL ready_outside_write: got %b, required 1", rx_ready);
            end
         end
      end
   end

   // Queues a frame for the words in word_q; bad selects a wrong checksum byte
   task automatic build_frame(input logic [15:0] n, input bit bad, input bit push_exp);
      logic [7:0] cs;
      cs = n[7:0] ^ n[15:8];
      tx_q.push_back(8'hA5);
      tx_q.push_back(n[7:0]);
      tx_q.push_back(n[15:8]);
      for (int i = 0; i < word_q.size(); i++) begin
         tx_q.push_back(word_q[i][7:0]);
         tx_q.push_back(word_q[i][15:8]);
         cs = cs ^ word_q[i][7:0] ^ word_q[i][15:8];
         if (push_exp) exp_q.push_back({word_q[i], 16'(2 * i)});
      end
      if (bad) tx_q.push_back((cs != 8'h00) ? 8'h00 : 8'hFF);
      else     tx_q.push_back(cs);
   endtask

   // Presents one byte (called at a negedge) and returns at the negedge after it is accepted
   task automatic send_byte(input logic [7:0] b);
      int guard;
      rx_data  = b;
      rx_valid = 1'b1;
      guard    = 0;
      while (rx_ready !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) begin
         tests_run++;
         tests_failed++;
         $display("FAIL ready_timeout: got rx_ready=%b for 20 cycles, required 1", rx_ready);
      end
      @(negedge clk);
   endtask

   task automatic send_tx(input bit gaps);
      while (tx_q.size() != 0) begin
         send_byte(tx_q.pop_front());
         if (gaps && ($urandom_range(0, 1) == 1)) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(1, 2)) @(negedge clk);
         end
      end
      rx_valid = 1'b0;
   endtask

   task automatic check_end(input string name, input bit exp_done, input int exp_pulses, input int p0);
      repeat (2) @(negedge clk);
      tests_run += 5;
      if (core_rstz !== exp_done) begin
         tests_failed++;
         $display("FAIL %s core_rstz: got %b, required %b", name, core_rstz, exp_done);
      end
      if (err !== !exp_done) begin
         tests_failed++;
         $display("FAIL %s err: got %b, required %b", name, err, !exp_done);
      end
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s busy: got %b, required 0", name, busy);
      end
      if (pulses - p0 != exp_pulses) begin
         tests_failed++;
         $display("FAIL %s pulse_count: got %0d, required %0d", name, pulses - p0, exp_pulses);
      end
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL %s writes_missing: got %0d pending, required 0", name, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic check_reset_outputs(input string name);
      tests_run += 7;
      if (pg !== 1'b0)         begin tests_failed++; $display("FAIL %s pg: got %b, required 0", name, pg); end
      if (pg_instr !== 16'h0)  begin tests_failed++; $display("FAIL %s pg_instr: got %h, required 0000", name, pg_instr); end
      if (pg_addr !== 16'h0)   begin tests_failed++; $display("FAIL %s pg_addr: got %h, required 0000", name, pg_addr); end
      if (core_rstz !== 1'b0)  begin tests_failed++; $display("FAIL %s core_rstz: got %b, required 0", name, core_rstz); end
      if (busy !== 1'b0)       begin tests_failed++; $display("FAIL %s busy: got %b, required 0", name, busy); end
      if (err !== 1'b0)        begin tests_failed++; $display("FAIL %s err: got %b, required 0", name, err); end
      if (rx_ready !== 1'b1)   begin tests_failed++; $display("FAIL %s rx_ready: got %b, required 1", name, rx_ready); end
   endtask

   task automatic test_reset();
      rstz = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rstz = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int p0 = pulses;
      word_q = '{16'h1234, 16'hABCD};
      build_frame(16'd2, 1'b0, 1'b1);
      send_tx(1'b0);
      check_end("basic", 1'b1, 2, p0);
   endtask

   task automatic test_bad_checksum();
      int p0 = pulses;
      word_q = '{16'h1234, 16'hABCD};
      build_frame(16'd2, 1'b1, 1'b1);
      send_tx(1'b0);
      check_end("bad_csum", 1'b0, 2, p0);
   endtask

   task automatic test_too_long();
      int p0 = pulses;
      tx_q = '{8'hA5, 8'h01, 8'h08};
      send_tx(1'b0);
      tests_run++;
      if (err !== 1'b1) begin
         tests_failed++;
         $display("FAIL too_long_immediate_err: got %b, required 1", err);
      end
      check_end("too_long", 1'b0, 0, p0);
      // a non-sync byte leaves the error sticky
      send_byte(8'h3C);
      rx_valid = 1'b0;
      @(negedge clk);
      tests_run++;
      if (err !== 1'b1) begin
         tests_failed++;
         $display("FAIL err_sticky: got %b, required 1", err);
      end
   endtask

   task automatic test_zero_len();
      int p0 = pulses;
      word_q.delete();
      build_frame(16'd0, 1'b0, 1'b1);
      send_tx(1'b0);
      check_end("zero_len", 1'b1, 0, p0);
   endtask

   task automatic test_back_to_back();
      int p0 = pulses;
      word_q = '{16'hBEEF};
      build_frame(16'd1, 1'b0, 1'b1);
      send_tx(1'b0);
      check_end("continuous_1word", 1'b1, 1, p0);
   endtask

   task automatic test_sync_as_data();
      int p0 = pulses;
      word_q = '{16'hA5A5, 16'h00A5};
      for (int i = 0; i < 4; i++) word_q.push_back(16'($urandom));
      build_frame(16'(word_q.size()), 1'b0, 1'b1);
      send_tx(1'b1);
      check_end("sync_as_data", 1'b1, 6, p0);
   endtask

   task automatic test_reset_in_write();
      int p0 = pulses;
      tx_q = '{8'hA5, 8'h01, 8'h00, 8'h34};
      send_tx(1'b0);
      rx_data  = 8'h12;
      rx_valid = 1'b1;
      @(posedge clk);
      #1 rstz  = 1'b0;
      rx_valid = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset_in_write");
      tests_run++;
      if (pulses != p0) begin
         tests_failed++;
         $display("FAIL reset_in_write pulse_count: got %0d, required 0", pulses - p0);
      end
      rstz = 1'b1;
      @(negedge clk);
      test_basic();
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_bad_checksum();
      test_too_long();
      test_zero_len();
      test_back_to_back();
      test_sync_as_data();
      test_reset_in_write();
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
